// File: rtl/dlf_gear_ctrl.sv
// rtl/dlf_gear_ctrl.sv - lock detector and gear-shift controller for a digital loop filter
module dlf_gear_ctrl #(
  parameter int inout_width = 8,
  parameter int LOCK_THR    = 4,
  parameter int UNLOCK_THR  = 32,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_CNT  = 4,
  parameter int BLANK       = 8,
  parameter int ACQ_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sample_vld,
  input  logic [inout_width-1:0] master_in,
  input  logic                   lead,
  output logic [1:0]             gear,
  output logic                   filter_clr,
  output logic                   locked,
  output logic                   lost_lock,
  output logic [2:0]             state
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int UW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam int TW = (ACQ_TIMEOUT > 1) ? $clog2(ACQ_TIMEOUT) : 1;

  localparam logic [inout_width-1:0] LOCK_THR_V   = inout_width'(LOCK_THR);
  localparam logic [inout_width-1:0] UNLOCK_THR_V = inout_width'(UNLOCK_THR);
  localparam logic [GW-1:0]          LOCK_CNT_V   = GW'(LOCK_CNT);
  localparam logic [GW-1:0]          LOCK_LAST    = GW'(LOCK_CNT - 1);
  localparam logic [UW-1:0]          UNLOCK_CNT_V = UW'(UNLOCK_CNT);
  localparam logic [UW-1:0]          UNLOCK_LAST  = UW'(UNLOCK_CNT - 1);
  localparam logic [BW-1:0]          BLANK_V      = BW'(BLANK);
  localparam logic [TW-1:0]          TIMEOUT_LAST = TW'(ACQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACQ  = 3'd1,
    S_TRK1 = 3'd2,
    S_TRK2 = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gear_q, gear_d;
  logic            locked_q, locked_d;
  logic            filter_clr_q, filter_clr_d;
  logic            lost_lock_q, lost_lock_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [GW-1:0]   good_q, good_d;
  logic [UW-1:0]   bad_q, bad_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic good_s, bad_s, counting, good_hit, bad_hit;

  // Sign of the error only steers the filter itself, never the gear decision.
  logic unused_lead;
  assign unused_lead = lead;

  assign good_s   = sample_vld && (master_in <= LOCK_THR_V);
  assign bad_s    = sample_vld && (master_in >= UNLOCK_THR_V);
  assign counting = (blank_q == '0);
  assign good_hit = counting && good_s && (good_q >= LOCK_LAST);
  assign bad_hit  = counting && bad_s && (bad_q >= UNLOCK_LAST);

  always_comb begin
    state_d      = state_q;
    filter_clr_d = 1'b0;
    lost_lock_d  = 1'b0;
    blank_d      = blank_q;
    good_d       = good_q;
    bad_d        = bad_q;
    timer_d      = '0;
    gear_d       = 2'd0;
    locked_d     = 1'b0;

    if (!counting) begin
      blank_d = blank_q - 1'b1;
      good_d  = '0;
      bad_d   = '0;
    end else if (sample_vld) begin
      good_d = good_s ? ((good_q == LOCK_CNT_V) ? good_q : good_q + 1'b1) : '0;
      bad_d  = bad_s ? ((bad_q == UNLOCK_CNT_V) ? bad_q : bad_q + 1'b1) : '0;
    end

    if (state_q == S_ACQ) timer_d = timer_q + 1'b1;

    case (state_q)
      S_IDLE: if (en) state_d = S_ACQ;
      S_ACQ: begin
        if (good_hit) begin
          state_d = S_TRK1;
        end else if (timer_q == TIMEOUT_LAST) begin
          filter_clr_d = 1'b1;
          timer_d      = '0;
        end
      end
      S_TRK1: begin
        if (good_hit)     state_d = S_TRK2;
        else if (bad_hit) state_d = S_ACQ;
      end
      S_TRK2: begin
        if (good_hit)     state_d = S_LOCK;
        else if (bad_hit) state_d = S_ACQ;
      end
      S_LOCK: if (bad_hit) state_d = S_ACQ;
      default: state_d = S_IDLE;
    endcase

    // Falling back to acquisition always restarts the filter from a clean slate.
    if (state_d != state_q) begin
      if (state_d == S_ACQ) filter_clr_d = 1'b1;
      if (state_q == S_LOCK) lost_lock_d = 1'b1;
    end
    if (state_d != S_ACQ || state_d != state_q) begin
      if (!(state_d == S_ACQ && state_q == S_ACQ)) timer_d = '0;
    end

    if (!en) begin
      state_d      = S_IDLE;
      filter_clr_d = 1'b0;
      lost_lock_d  = (state_q == S_LOCK);
      timer_d      = '0;
      blank_d      = '0;
      good_d       = '0;
      bad_d        = '0;
    end else if (filter_clr_d || (state_d != state_q)) begin
      blank_d = BLANK_V;
      good_d  = '0;
      bad_d   = '0;
    end

    case (state_d)
      S_TRK1:  gear_d = 2'd1;
      S_TRK2:  gear_d = 2'd2;
      S_LOCK:  gear_d = 2'd2;
      default: gear_d = 2'd0;
    endcase
    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gear_q       <= 2'd0;
      locked_q     <= 1'b0;
      filter_clr_q <= 1'b0;
      lost_lock_q  <= 1'b0;
      blank_q      <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      gear_q       <= gear_d;
      locked_q     <= locked_d;
      filter_clr_q <= filter_clr_d;
      lost_lock_q  <= lost_lock_d;
      blank_q      <= blank_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      timer_q      <= timer_d;
    end
  end

  assign gear       = gear_q;
  assign filter_clr = filter_clr_q;
  assign locked     = locked_q;
  assign lost_lock  = lost_lock_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// tb/tb_dlf_gear_ctrl.sv - directed self-checking bench for dlf_gear_ctrl
module tb_dlf_gear_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sample_vld;
  logic [7:0] master_in;
  logic       lead;
  logic [1:0] gear;
  logic       filter_clr;
  logic       locked;
  logic       lost_lock;
  logic [2:0] state;

  int total;
  int bad;

  dlf_gear_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sample_vld (sample_vld),
    .master_in  (master_in),
    .lead       (lead),
    .gear       (gear),
    .filter_clr (filter_clr),
    .locked     (locked),
    .lost_lock  (lost_lock),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then enable with good samples for n cycles (25 -> just entered TRK1, 49 -> TRK2).
  task automatic start_and_run(input int n);
    rst = 1'b1; en = 1'b0; sample_vld = 1'b0; master_in = 8'd0;
    tick();
    rst = 1'b0; en = 1'b1; sample_vld = 1'b1; master_in = 8'd2;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    rst = 1'b1; en = 1'b1; sample_vld = 1'b1; master_in = 8'd2;
    tick(); tick();
    obs = {state, gear, filter_clr, locked};
    total++;
    if (obs !== 7'd0 || lost_lock !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %b/%b expected 0000000/0", obs, lost_lock);
    end
    rst = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_acquire;
    logic [7:0] obs, exp;
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; sample_vld = 1'b1; master_in = 8'd2;
    for (int i = 1; i <= 73; i++) begin
      tick();
      exp[7:5] = (i < 25) ? 3'd1 : (i < 49) ? 3'd2 : (i < 73) ? 3'd3 : 3'd4;
      exp[4:3] = (i < 25) ? 2'd0 : (i < 49) ? 2'd1 : 2'd2;
      exp[2]   = (i == 1);
      exp[1]   = (i >= 73);
      exp[0]   = 1'b0;
      obs = {state, gear, filter_clr, locked, lost_lock};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL acquire cycle %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_lock_loss;
    logic [7:0] obs;
    repeat (8) tick();
    master_in = 8'd40;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (state !== 3'd4 || locked !== 1'b1) begin
        bad++;
        $display("FAIL lock_hold bad %0d: got state=%0d locked=%0d expected 4/1", i, state, locked);
      end
    end
    tick();
    obs = {state, gear, filter_clr, locked, lost_lock};
    total++;
    if (obs !== 8'b001_00_1_0_1) begin
      bad++;
      $display("FAIL lock_loss: got %b expected 00100101", obs);
    end
    master_in = 8'd2;
    tick();
    total++;
    if (filter_clr !== 1'b0 || lost_lock !== 1'b0 || state !== 3'd1) begin
      bad++;
      $display("FAIL lock_loss_pulse: got clr=%0d lost=%0d state=%0d expected 0/0/1", filter_clr, lost_lock, state);
    end
  endtask

  task automatic test_good_clear;
    start_and_run(25);
    repeat (8) tick();
    repeat (15) tick();
    master_in = 8'd10; tick();
    master_in = 8'd2;
    repeat (15) tick();
    total++;
    if (state !== 3'd2 || gear !== 2'd1) begin
      bad++;
      $display("FAIL good_clear_hold: got state=%0d gear=%0d expected 2/1", state, gear);
    end
    tick();
    total++;
    if (state !== 3'd3 || gear !== 2'd2 || filter_clr !== 1'b0) begin
      bad++;
      $display("FAIL good_clear_advance: got state=%0d gear=%0d clr=%0d expected 3/2/0", state, gear, filter_clr);
    end
  endtask

  task automatic test_bad_clear;
    start_and_run(25);
    repeat (8) tick();
    master_in = 8'd40; repeat (3) tick();
    master_in = 8'd10; tick();
    master_in = 8'd40; repeat (3) tick();
    total++;
    if (state !== 3'd2 || filter_clr !== 1'b0) begin
      bad++;
      $display("FAIL bad_clear_hold: got state=%0d clr=%0d expected 2/0", state, filter_clr);
    end
    tick();
    total++;
    if (state !== 3'd1 || gear !== 2'd0 || filter_clr !== 1'b1 || lost_lock !== 1'b0) begin
      bad++;
      $display("FAIL bad_fallback: got state=%0d gear=%0d clr=%0d lost=%0d expected 1/0/1/0", state, gear, filter_clr, lost_lock);
    end
  endtask

  task automatic test_timeout;
    rst = 1'b1; en = 1'b0; tick();
    rst = 1'b0; en = 1'b1; sample_vld = 1'b1; master_in = 8'd20;
    for (int i = 1; i <= 2050; i++) begin
      tick();
      total++;
      if (filter_clr !== ((i == 1) || (i == 1025) || (i == 2049)) || state !== 3'd1) begin
        bad++;
        $display("FAIL timeout cycle %0d: got clr=%0d state=%0d", i, filter_clr, state);
      end
    end
  endtask

  task automatic test_timeout_priority;
    rst = 1'b1; en = 1'b0; tick();
    rst = 1'b0; en = 1'b1; sample_vld = 1'b1; master_in = 8'd20;
    repeat (1009) tick();
    master_in = 8'd2;
    repeat (15) tick();
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL prio_pre: got state=%0d expected 1", state);
    end
    tick();
    total++;
    if (state !== 3'd2 || gear !== 2'd1 || filter_clr !== 1'b0) begin
      bad++;
      $display("FAIL prio_advance_over_timeout: got state=%0d gear=%0d clr=%0d expected 2/1/0", state, gear, filter_clr);
    end
  endtask

  task automatic test_disable;
    start_and_run(49);
    repeat (3) tick();
    en = 1'b0;
    tick();
    total++;
    if (state !== 3'd0 || gear !== 2'd0 || filter_clr !== 1'b0 || locked !== 1'b0 || lost_lock !== 1'b0) begin
      bad++;
      $display("FAIL disable: got state=%0d gear=%0d clr=%0d locked=%0d lost=%0d expected all 0", state, gear, filter_clr, locked, lost_lock);
    end
  endtask

  task automatic test_reset_midblank;
    start_and_run(25);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({state, gear, filter_clr, locked, lost_lock} !== 8'd0) begin
      bad++;
      $display("FAIL reset_midblank: got %b expected 00000000", {state, gear, filter_clr, locked, lost_lock});
    end
    rst = 1'b0;
    tick();
    total++;
    if (state !== 3'd1 || filter_clr !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart: got state=%0d clr=%0d expected 1/1", state, filter_clr);
    end
  endtask

  task automatic test_gaps;
    start_and_run(49);
    repeat (8) tick();
    for (int k = 1; k <= 16; k++) begin
      sample_vld = 1'b1; master_in = 8'd2;
      tick();
      if (k < 16) begin
        sample_vld = 1'b0; master_in = 8'd40;
        tick();
        total++;
        if (state !== 3'd3) begin
          bad++;
          $display("FAIL gaps_hold after %0d: got state=%0d expected 3", k, state);
        end
      end
    end
    total++;
    if (state !== 3'd4 || locked !== 1'b1 || gear !== 2'd2) begin
      bad++;
      $display("FAIL gaps_lock: got state=%0d locked=%0d gear=%0d expected 4/1/2", state, locked, gear);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b0; sample_vld = 1'b0; master_in = 8'd0; lead = 1'b0;
    test_reset();
    lead = 1'b1;
    test_acquire();
    test_lock_loss();
    test_good_clear();
    test_bad_clear();
    test_timeout();
    test_timeout_priority();
    test_disable();
    test_reset_midblank();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dlf_gear_ctrl.md
DLF_GEAR_CTRL -- requirements
Module: dlf_gear_ctrl

Interface
REQ-001 Parameter inout_width, default 8: width of the phase-error magnitude input.
REQ-002 Parameter LOCK_THR, default 4: magnitude at or below which a sample counts as "good".
REQ-003 Parameter UNLOCK_THR, default 32: magnitude at or above which a sample counts as "bad"; LOCK_THR < UNLOCK_THR is mandatory.
REQ-004 Parameter LOCK_CNT, default 16: number of consecutive good samples needed to advance one gear.
REQ-005 Parameter UNLOCK_CNT, default 4: number of consecutive bad samples needed to fall back to acquisition.
REQ-006 Parameter BLANK, default 8: number of sample-ignore cycles after every gear change or filter clear.
REQ-007 Parameter ACQ_TIMEOUT, default 1024: number of cycles in ACQ before a forced filter clear.
REQ-008 clk, input, 1: single clock, the same clock as the loop filter.
REQ-009 rst, input, 1: synchronous, active-high reset.
REQ-010 en, input, 1: loop enable.
REQ-011 sample_vld, input, 1: master_in/lead hold a valid ADC sample this cycle.
REQ-012 master_in, input, inout_width: phase-error magnitude.
REQ-013 lead, input, 1: sign of the phase error; 1 means feedback leads; lead has no effect on gear decisions.
REQ-014 gear, output, 2: loop-filter coefficient set select; 0 is widest bandwidth, 2 is narrowest.
REQ-015 filter_clr, output, 1: single-cycle pulse that clears the loop-filter delay lines.
REQ-016 locked, output, 1: loop is declared locked.
REQ-017 lost_lock, output, 1: single-cycle pulse on exit from LOCK.
REQ-018 state, output, 3: current FSM state encoding (IDLE=0, ACQ=1, TRK1=2, TRK2=3, LOCK=4).

Function
REQ-019 All outputs SHALL be registered; every decision is visible in the cycle after the qualifying sample.
REQ-020 good = sample_vld and master_in <= LOCK_THR; bad = sample_vld and master_in >= UNLOCK_THR.
REQ-021 good_cnt: increments on good, clears on any valid non-good sample, holds when sample_vld=0.
REQ-022 bad_cnt: increments on bad, clears on any valid non-bad sample, holds when sample_vld=0.
REQ-023 Both counters SHALL saturate at their thresholds.
REQ-024 While the blank counter is nonzero, the blank counter decrements, good_cnt and bad_cnt are held at 0, and samples are ignored.
REQ-025 On entry to any state other than IDLE, and on every filter_clr, the blank counter loads BLANK and both counters clear.
REQ-026 IDLE: gear=0, locked=0; if en=1, go to ACQ and assert filter_clr for one cycle.
REQ-027 ACQ (gear=0): good_cnt reaching LOCK_CNT moves to TRK1.
REQ-028 ACQ timer: counts cycles spent in ACQ; when it reaches ACQ_TIMEOUT, filter_clr pulses, the timer restarts, and the state stays ACQ.
REQ-029 TRK1 (gear=1): LOCK_CNT good samples -> TRK2; UNLOCK_CNT bad samples -> ACQ.
REQ-030 TRK2 (gear=2): LOCK_CNT good samples -> LOCK; UNLOCK_CNT bad samples -> ACQ.
REQ-031 LOCK (gear=2, locked=1): UNLOCK_CNT bad samples -> ACQ, with lost_lock pulsed and locked cleared in the same cycle.
REQ-032 Every transition to ACQ SHALL pulse filter_clr.
REQ-033 Transitions to TRK1, TRK2 and LOCK SHALL NOT pulse filter_clr.
REQ-034 gear SHALL change in the same cycle as state.
REQ-035 Priority: en=0 beats every other condition (next state IDLE, no filter_clr), which beats gear advance, which beats ACQ timeout.
REQ-036 In ACQ, the timer SHALL reset on every ACQ entry and on every gear advance out of ACQ.
REQ-037 filter_clr and lost_lock SHALL never be asserted for two consecutive cycles.

Reset
REQ-038 While rst=1 at a clk edge, the block goes to IDLE with gear=0, filter_clr=0, locked=0, lost_lock=0, state=0, and all counters and timers cleared.
REQ-039 rst overrides en and samples, including in the middle of blanking or in the middle of a count.

Verification
REQ-040 Acquire to lock: rst, then en=1 with master_in=2 every cycle -> filter_clr pulses once; gear steps 0->1->2 and then locked=1, each step 8 blank + 16 good = 24 cycles apart.
REQ-041 Lock loss: while in LOCK, apply 4 consecutive samples of master_in=40 -> next cycle state=ACQ, gear=0, lost_lock=1 and filter_clr=1 for one cycle, locked=0.
REQ-042 Counter clearing: in TRK1, apply 15 good samples, then one sample of master_in=10, then 15 good samples -> gear stays 1.
REQ-043 Bad-count clearing: in TRK1, apply 3 bad samples, then master_in=10, then 3 bad samples -> no fallback.
REQ-044 Timeout: en=1 with master_in=20 constant -> filter_clr pulses at 1 cycle and then every 1024 cycles; state stays ACQ.
REQ-045 Disable and reset: en=0 mid-TRK2 -> IDLE next cycle, no filter_clr. rst=1 mid-blank in TRK1 -> all outputs 0 next cycle.
REQ-046 sample_vld=0 gaps: in TRK2, good samples interleaved with invalid cycles -> counts hold across the gaps, and lock is reached after 16 valid good samples.
